timer_control: RTL and testbench

//  Upstream control stage for MinutesCounter in the MonitorVGA timer.
//  - Conditions the raw push-buttons and the direction switch.
//  - Generates the 1 Hz count enable.
//  - Runs the SET/RUN/PAUSE/DONE state machine.
//  - Drives MinutesCounter's enable, reset, forward, incrementSeconds and incrementMinutes.
//  - Consumes MinutesCounter's finish.

---
 rtl/timer_control_if.sv | 24 ++
 rtl/timer_control.sv | 109 ++++++++++
 tb/tb_timer_control.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/timer_control_if.sv
// timer_control_if: push-buttons, direction switch and MinutesCounter handshake for timer_control
interface timer_control_if;
  logic btn_start;
  logic btn_clear;
  logic btn_inc_sec;
  logic btn_inc_min;
  logic sw_direction;
  logic finish;
  logic enable;
  logic counter_reset;
  logic forward;
  logic incrementSeconds;
  logic incrementMinutes;
  logic running;
  logic alarm;
  modport master (
    output btn_start, btn_clear, btn_inc_sec, btn_inc_min, sw_direction, finish,
    input  enable, counter_reset, forward, incrementSeconds, incrementMinutes, running, alarm
  );
  modport slave (
    input  btn_start, btn_clear, btn_inc_sec, btn_inc_min, sw_direction, finish,
    output enable, counter_reset, forward, incrementSeconds, incrementMinutes, running, alarm
  );
endinterface

// File: rtl/timer_control.sv
// timer_control: debounces the buttons, generates the count tick and runs SET/RUN/PAUSE/DONE for MinutesCounter
module timer_control #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           reset,
  timer_control_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] SET   = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [4:0]    raw, sync1, sync2, level, accept;
  logic [3:0]    press;
  logic [DW-1:0] dbCnt [5];
  logic [1:0]    state;
  logic [PW-1:0] prescaler;
  logic          wrap, startP, clearP;
  logic          enable, counterReset, forward, incSec, incMin;

  assign raw = {bus.sw_direction, bus.btn_inc_min, bus.btn_inc_sec, bus.btn_clear, bus.btn_start};

  // accept fires in the last stable cycle, so the press is seen one cycle before the level updates
  always_comb begin
    accept = '0;
    for (int i = 0; i < 5; i++)
      accept[i] = (sync2[i] != level[i]) && (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1));
  end

  assign press  = accept[3:0] & sync2[3:0];
  assign startP = press[0];
  assign clearP = press[1];
  assign wrap   = prescaler == PW'(TICK_DIV - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < 5; i++) dbCnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level ^ accept;
      for (int i = 0; i < 5; i++)
        dbCnt[i] <= (sync2[i] == level[i] || accept[i]) ? '0 : dbCnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SET;
      prescaler    <= '0;
      enable       <= 1'b0;
      counterReset <= 1'b0;
      forward      <= 1'b0;
      incSec       <= 1'b0;
      incMin       <= 1'b0;
    end else begin
      enable       <= 1'b0;
      counterReset <= 1'b0;
      incSec       <= 1'b0;
      incMin       <= 1'b0;
      if (clearP) begin
        state        <= SET;
        counterReset <= 1'b1;
        prescaler    <= '0;
      end else begin
        case (state)
          SET: begin
            forward <= level[4];
            if (startP) begin
              state     <= RUN;
              prescaler <= '0;
            end else begin
              incSec <= press[2];
              incMin <= press[3];
            end
          end
          RUN: begin
            if (bus.finish) state <= DONE;
            else if (startP) state <= PAUSE;
            else begin
              prescaler <= wrap ? '0 : prescaler + 1'b1;
              enable    <= wrap;
            end
          end
          PAUSE: if (startP) state <= RUN;
          DONE: if (startP) begin
            state        <= SET;
            counterReset <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.enable           = enable;
  assign bus.counter_reset    = counterReset;
  assign bus.forward          = forward;
  assign bus.incrementSeconds = incSec;
  assign bus.incrementMinutes = incMin;
  assign bus.running          = state == RUN;
  assign bus.alarm            = state == DONE;
endmodule

// File: tb/tb_timer_control.sv
// tb_timer_control: vector table for button conditioning plus a pulse scoreboard for run/pause/done/clear/reset sequences
module tb_timer_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int nChecks = 0;
  int nFail = 0;

  typedef struct { int kind; int at; } ev_t;
  typedef struct { string name; logic incSec; logic incMin; int hold; logic expSec; logic expMin; } vec_t;
  ev_t q[$];
  vec_t vecs[5];
  string kindName[4] = '{"incrementSeconds", "incrementMinutes", "counter_reset", "enable"};

  timer_control_if bus();
  timer_control #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic push(input int kind, input int at);
    q.push_back('{kind, at});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every pulse output must match the head of the queue in kind and cycle; overdue entries are misses
  logic [3:0] obs;
  always @(negedge clk) begin
    if (reset) begin
      obs = {bus.enable, bus.counter_reset, bus.incrementMinutes, bus.incrementSeconds};
      while (q.size() > 0 && q[0].at < cyc) begin
        nChecks++;
        nFail++;
        $display("FAIL missing_%s: got no pulse, expected one at cycle %0d", kindName[q[0].kind], q[0].at);
        void'(q.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
        if (obs[k]) begin
          nChecks++;
          if (q.size() == 0 || q[0].kind != k || q[0].at != cyc) begin
            nFail++;
            $display("FAIL pulse_%s: got pulse at cycle %0d, expected kind %0d at cycle %0d", kindName[k], cyc,
                     q.size() > 0 ? q[0].kind : -1, q.size() > 0 ? q[0].at : -1);
          end else void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int c0, d, e, f, g, h, k;
    vecs[0] = '{"inc_sec_hold20", 1'b1, 1'b0, 20, 1'b1, 1'b0};
    vecs[1] = '{"inc_sec_glitch3", 1'b1, 1'b0, 3, 1'b0, 1'b0};
    vecs[2] = '{"inc_sec_hold4", 1'b1, 1'b0, 4, 1'b1, 1'b0};
    vecs[3] = '{"inc_min_hold8", 1'b0, 1'b1, 8, 1'b0, 1'b1};
    vecs[4] = '{"inc_both_hold6", 1'b1, 1'b1, 6, 1'b1, 1'b1};
    bus.btn_start = 0;
    bus.btn_clear = 0;
    bus.btn_inc_sec = 0;
    bus.btn_inc_min = 0;
    bus.sw_direction = 0;
    bus.finish = 0;
    tick(3);
    check("reset_outputs", {1'b0, bus.enable, bus.counter_reset, bus.forward, bus.incrementSeconds,
                            bus.incrementMinutes, bus.running, bus.alarm}, 8'h00);
    reset = 1;
    tick(2);

    foreach (vecs[i]) begin
      c0 = cyc;
      bus.btn_inc_sec = vecs[i].incSec;
      bus.btn_inc_min = vecs[i].incMin;
      if (vecs[i].expSec) push(0, c0 + 6);
      if (vecs[i].expMin) push(1, c0 + 6);
      tick(vecs[i].hold);
      bus.btn_inc_sec = 0;
      bus.btn_inc_min = 0;
      tick(10);
      check({vecs[i].name, "_running"}, {7'd0, bus.running}, 8'h00);
      check({vecs[i].name, "_alarm"}, {7'd0, bus.alarm}, 8'h00);
    end

    bus.sw_direction = 1;
    tick(8);
    check("set_forward_follows", {7'd0, bus.forward}, 8'h01);

    c0 = cyc;
    for (int i = 0; i < 5; i++) push(3, c0 + 16 + 10 * i);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(c0 + 14);
    check("run_running", {7'd0, bus.running}, 8'h01);
    check("run_forward", {7'd0, bus.forward}, 8'h01);
    bus.sw_direction = 0;
    waitUntil(c0 + 40);
    check("run_forward_frozen", {7'd0, bus.forward}, 8'h01);

    d = c0 + 57;
    waitUntil(d);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(d + 8);
    check("pause_running", {7'd0, bus.running}, 8'h00);
    check("pause_alarm", {7'd0, bus.alarm}, 8'h00);

    e = d + 30;
    waitUntil(e);
    push(3, e + 10);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(e + 8);
    check("resume_running", {7'd0, bus.running}, 8'h01);

    f = e + 13;
    waitUntil(f);
    bus.btn_start = 1;
    tick(5);
    bus.finish = 1;
    tick(1);
    bus.btn_start = 0;
    waitUntil(f + 8);
    check("done_alarm", {7'd0, bus.alarm}, 8'h01);
    check("done_running", {7'd0, bus.running}, 8'h00);

    g = f + 30;
    waitUntil(g);
    push(2, g + 6);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(g + 8);
    check("done_exit_alarm", {7'd0, bus.alarm}, 8'h00);
    bus.finish = 0;

    h = g + 20;
    waitUntil(h);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(h + 10);
    push(2, h + 16);
    bus.btn_clear = 1;
    tick(6);
    bus.btn_clear = 0;
    waitUntil(h + 18);
    check("clear_running", {7'd0, bus.running}, 8'h00);

    tick(10);
    bus.sw_direction = 1;
    tick(10);
    check("set_forward_again", {7'd0, bus.forward}, 8'h01);
    k = cyc;
    push(3, k + 16);
    bus.btn_start = 1;
    tick(6);
    bus.btn_start = 0;
    waitUntil(k + 23);
    #1 reset = 0;
    #1;
    check("async_reset_outputs", {1'b0, bus.enable, bus.counter_reset, bus.forward, bus.incrementSeconds,
                                  bus.incrementMinutes, bus.running, bus.alarm}, 8'h00);
    reset = 1;
    tick(3);
    check("after_reset_running", {7'd0, bus.running}, 8'h00);
    c0 = cyc;
    push(0, c0 + 6);
    bus.btn_inc_sec = 1;
    tick(6);
    bus.btn_inc_sec = 0;
    tick(12);
    check("scoreboard_drained", q.size(), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
